// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Entry layout is {pc, instr}; widths match the instruction memory.
package fetch_pkg;
  localparam int INS_ADDRESS = 9;
  localparam int DATA_W      = 32;
  localparam int PC_STEP     = 4;
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [INS_ADDRESS-1:0] pc;
    logic [DATA_W-1:0]      instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect input, decode handshake.
// master = fetch controller, slave = memory/execute/decode side.
interface fetch_queue_ctrl_if;
  logic [fetch_pkg::INS_ADDRESS-1:0] imem_ra;
  logic [fetch_pkg::DATA_W-1:0]      imem_rd;
  logic                              redirect_valid;
  logic [fetch_pkg::INS_ADDRESS-1:0] redirect_pc;
  logic                              out_valid;
  logic                              out_ready;
  logic [fetch_pkg::DATA_W-1:0]      out_instr;
  logic [fetch_pkg::INS_ADDRESS-1:0] out_pc;

  modport master (
    output imem_ra, out_valid, out_instr, out_pc,
    input  imem_rd, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_ra, out_valid, out_instr, out_pc,
    output imem_rd, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue_ctrl_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with synchronous clear.
// Head is read straight from storage; push and pop may coincide when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdat,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch sequencer: owns the PC, fills the prefetch queue, serves decode.
// Redirects flush the queue and restart fetch at the aligned target.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int                     DEPTH    = 4,
  parameter logic [INS_ADDRESS-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_ctrl_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [INS_ADDRESS-1:0] ALIGN    = ~(INS_ADDRESS'(3));
  localparam logic [INS_ADDRESS-1:0] START_PC = RESET_PC & ALIGN;

  logic [INS_ADDRESS-1:0] fetch_pc;
  logic [CW-1:0]          count;
  fetch_entry_t           head;
  fetch_entry_t           wdat;
  logic                   out_valid;
  logic                   push;
  logic                   pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & bus.out_ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push      = !bus.redirect_valid & ((count < CW'(DEPTH)) | pop);
  assign wdat      = '{pc: fetch_pc, instr: bus.imem_rd};

  always_ff @(posedge clk) begin
    if (reset)
      fetch_pc <= START_PC;
    else if (bus.redirect_valid)
      fetch_pc <= bus.redirect_pc & ALIGN;
    else if (push)
      fetch_pc <= fetch_pc + INS_ADDRESS'(PC_STEP);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdat  (wdat),
    .head  (head),
    .count (count)
  );

  assign bus.imem_ra   = reset ? START_PC : fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head.instr : NOP_INSTR;
  assign bus.out_pc    = out_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Randomized bench for fetch_queue_ctrl against a queue-based reference model.
module tb_fetch_queue_ctrl;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    int          pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem [128];
  ent_t        q[$];
  int          mpc;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  fetch_queue_ctrl_if ifc ();

  fetch_queue_ctrl #(.DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  assign ifc.imem_rd = mem[ifc.imem_ra[8:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks outputs for the current cycle, then advances the model across the edge.
  task automatic step();
    bit popped;
    #1;
    chk("out_valid", 32'(ifc.out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
    chk("out_pc",    32'(ifc.out_pc),    (q.size() != 0) ? q[0].pc : 0);
    chk("out_instr", ifc.out_instr,      (q.size() != 0) ? q[0].instr : 32'h00000013);
    chk("imem_ra",   32'(ifc.imem_ra),   reset ? 0 : mpc);
    @(posedge clk);
    if (reset) begin
      q.delete();
      mpc = 0;
    end else if (ifc.redirect_valid) begin
      q.delete();
      mpc = int'(ifc.redirect_pc) & 'h1FC;
    end else begin
      popped = ifc.out_ready && (q.size() != 0);
      if (popped) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{mpc, mem[mpc >> 2]});
        mpc = (mpc + 4) % 512;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    reset              = 1'b1;
    ifc.out_ready      = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    q.delete();
    mpc = 0;
    repeat (2) @(negedge clk);

    // Streaming straight out of reset.
    step();
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (8) step();

    // Fill with decode stalled, then a single pop while full.
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (6) step();
    chk("fill_ra", 32'(ifc.imem_ra), 32'h010);
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    chk("pop_push_ra", 32'(ifc.imem_ra), 32'h014);
    chk("pop_push_pc", 32'(ifc.out_pc), 32'h004);
    step();

    // Redirect while streaming.
    ifc.out_ready = 1'b1;
    repeat (3) step();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 9'h054;
    step();
    ifc.redirect_valid = 1'b0;
    chk("redir_r1_valid", 32'(ifc.out_valid), 32'd0);
    step();
    chk("redir_r2_pc", 32'(ifc.out_pc), 32'h054);
    repeat (2) step();

    // Misaligned target.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 9'h057;
    step();
    ifc.redirect_valid = 1'b0;
    step();
    chk("misalign_pc", 32'(ifc.out_pc), 32'h054);
    step();

    // Back-to-back redirects.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 9'h020;
    step();
    ifc.redirect_pc    = 9'h040;
    step();
    ifc.redirect_valid = 1'b0;
    step();
    chk("b2b_pc", 32'(ifc.out_pc), 32'h040);
    step();

    // Address wrap at the top of memory.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 9'h1F8;
    step();
    ifc.redirect_valid = 1'b0;
    step();
    chk("wrap_pc0", 32'(ifc.out_pc), 32'h1F8);
    step();
    chk("wrap_pc1", 32'(ifc.out_pc), 32'h1FC);
    step();
    chk("wrap_pc2", 32'(ifc.out_pc), 32'h000);
    step();

    // Reset with a full queue and decode ready.
    ifc.out_ready = 1'b0;
    repeat (6) step();
    ifc.out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_instr", ifc.out_instr, 32'h00000013);
    chk("rst_ra",    32'(ifc.imem_ra), 32'h000);
    step();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      ifc.out_ready      = ($urandom_range(0, 3) != 0);
      ifc.redirect_valid = ($urandom_range(0, 9) == 0);
      ifc.redirect_pc    = 9'($urandom_range(0, 511));
      reset              = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    ifc.redirect_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
